// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the parametrised multi-cycle controller.
//   - opcode constants (4-bit architectural opcode space)
//   - FSM state encoding (driven onto the 4-bit state port)
//   - memory-op and ALU-op codes
//   - two_word(): opcodes that carry a second {rd, rs} operand word
package ctrl_pkg;

  localparam logic [3:0] OP_END   = 4'h0;
  localparam logic [3:0] OP_CLR   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_COPY  = 4'h4;
  localparam logic [3:0] OP_INCR  = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_ADDR  = 4'h7;
  localparam logic [3:0] OP_SUBI  = 4'h8;
  localparam logic [3:0] OP_SUBR  = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_JMPZ  = 4'hD;
  localparam logic [3:0] OP_JMPNZ = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_OPFETCH = 4'd3,
    S_EXEC    = 4'd4
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_IM_RD = 2'b01;
  localparam logic [1:0] MEM_DM_RD = 2'b10;
  localparam logic [1:0] MEM_DM_WR = 2'b11;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ABUS = 4'd1;
  localparam logic [3:0] ALU_INCR = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;

  function automatic logic two_word(input logic [3:0] op);
    case (op)
      OP_COPY, OP_ADDI, OP_ADDR, OP_SUBI, OP_SUBR,
      OP_SHL, OP_SHR, OP_JMP, OP_JMPZ, OP_JMPNZ: two_word = 1'b1;
      default:                                   two_word = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_fsm_param_decode.sv
// ctrl_decode: combinational EXEC-state control bundle.
//   in : opcode (latched 4-bit), opnd (current IR word), z_flag
//   out: pc_inc, branch, rst_en/rst_sel, a/b/c_sel, c_we, alu_op, mem_op,
//        mux2_imm
// Two-word ops read {rd, rs} from the operand word. One-word ops that name a
// register (CLR, INCR) take it from the low RW bits of the instruction word,
// since the upper bits hold the opcode.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int RW   = 4,
  parameter int AOPW = 4
) (
  input  logic [3:0]      opcode,
  input  logic [2*RW-1:0] opnd,
  input  logic            z_flag,
  output logic            pc_inc,
  output logic            branch,
  output logic            rst_en,
  output logic [RW-1:0]   rst_sel,
  output logic [RW-1:0]   a_sel,
  output logic [RW-1:0]   b_sel,
  output logic [RW-1:0]   c_sel,
  output logic            c_we,
  output logic [AOPW-1:0] alu_op,
  output logic [1:0]      mem_op,
  output logic            mux2_imm
);

  logic [RW-1:0] rd, rs;
  logic [3:0]    alu4;

  assign rd     = opnd[2*RW-1:RW];
  assign rs     = opnd[RW-1:0];
  assign alu_op = AOPW'(alu4);

  always_comb begin
    pc_inc   = 1'b0;
    branch   = 1'b0;
    rst_en   = 1'b0;
    rst_sel  = '0;
    a_sel    = '0;
    b_sel    = '0;
    c_sel    = '0;
    c_we     = 1'b0;
    alu4     = ALU_NONE;
    mem_op   = MEM_NONE;
    mux2_imm = 1'b0;
    case (opcode)
      OP_CLR:   begin rst_en = 1'b1; rst_sel = rs; end
      OP_LOAD:  mem_op = MEM_DM_RD;
      OP_STORE: mem_op = MEM_DM_WR;
      OP_COPY:  begin a_sel = rs; c_sel = rd; c_we = 1'b1; alu4 = ALU_ABUS; pc_inc = 1'b1; end
      OP_INCR:  begin a_sel = rs; c_sel = rs; c_we = 1'b1; alu4 = ALU_INCR; end
      OP_ADDI, OP_SUBI, OP_SHL, OP_SHR: begin
        a_sel = rd; c_sel = rd; mux2_imm = 1'b1; c_we = 1'b1; pc_inc = 1'b1;
        case (opcode)
          OP_ADDI: alu4 = ALU_ADD;
          OP_SUBI: alu4 = ALU_SUB;
          OP_SHL:  alu4 = ALU_SHL;
          default: alu4 = ALU_SHR;
        endcase
      end
      OP_ADDR, OP_SUBR: begin
        a_sel = rd; c_sel = rd; b_sel = rs; c_we = 1'b1; pc_inc = 1'b1;
        alu4  = (opcode == OP_ADDR) ? ALU_ADD : ALU_SUB;
      end
      OP_JMP:   branch = 1'b1;
      // Not-taken conditional branch still has to step over the target word.
      OP_JMPZ:  begin branch = z_flag;  pc_inc = ~z_flag; end
      OP_JMPNZ: begin branch = ~z_flag; pc_inc = z_flag;  end
      OP_NOP:   ;
      default:  ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param: multi-cycle control unit, IDLE/FETCH/DECODE/OPFETCH/EXEC.
//   in : clk, rst (sync, active high), start, instr[IW], z_flag, mem_ready
//   out: pc_inc, branch, rst_en, rst_sel, a/b/c_sel, c_we, alu_op, mem_op,
//        ir_en, mux2_imm, busy, done, err, state[4]
// Outputs are decoded from the registered state, latched opcode and the IR
// word. Every output is forced low while rst is high so an aborted
// instruction never writes in the reset cycle.
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int RW   = 4,
  parameter int OPW  = 4,
  parameter int AOPW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*RW-1:0] instr,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            pc_inc,
  output logic            branch,
  output logic            rst_en,
  output logic [RW-1:0]   rst_sel,
  output logic [RW-1:0]   a_sel,
  output logic [RW-1:0]   b_sel,
  output logic [RW-1:0]   c_sel,
  output logic            c_we,
  output logic [AOPW-1:0] alu_op,
  output logic [1:0]      mem_op,
  output logic            ir_en,
  output logic            mux2_imm,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      state
);

  localparam int IW = 2 * RW;

  state_t     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic       err_q, err_d, done_q, done_d;

  logic [OPW-1:0] opc_in;
  logic [3:0]     opc4;
  logic           illegal, mem_wait_op;

  assign opc_in      = instr[IW-1 -: OPW];
  assign opc4        = 4'(opc_in);
  // Only reachable with OPW > 4: opcode space beyond the 16 defined ops.
  assign illegal     = (32'(opc_in) > 32'd15);
  assign mem_wait_op = (opcode_q == OP_LOAD) || (opcode_q == OP_STORE);

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE:    if (start) begin state_d = S_FETCH; err_d = 1'b0; end
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = opc4;
        if (illegal) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (opc4 == OP_END) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (two_word(opc4)) begin
          state_d = S_OPFETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_OPFETCH: if (mem_ready) state_d = S_EXEC;
      S_EXEC:    if (!(mem_wait_op && !mem_ready)) state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_END;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  logic            d_pc_inc, d_branch, d_rst_en, d_c_we, d_mux2_imm;
  logic [RW-1:0]   d_rst_sel, d_a_sel, d_b_sel, d_c_sel;
  logic [AOPW-1:0] d_alu_op;
  logic [1:0]      d_mem_op;

  ctrl_decode #(.RW(RW), .AOPW(AOPW)) u_dec (
    .opcode   (opcode_q),
    .opnd     (instr),
    .z_flag   (z_flag),
    .pc_inc   (d_pc_inc),
    .branch   (d_branch),
    .rst_en   (d_rst_en),
    .rst_sel  (d_rst_sel),
    .a_sel    (d_a_sel),
    .b_sel    (d_b_sel),
    .c_sel    (d_c_sel),
    .c_we     (d_c_we),
    .alu_op   (d_alu_op),
    .mem_op   (d_mem_op),
    .mux2_imm (d_mux2_imm)
  );

  always_comb begin
    pc_inc   = 1'b0;
    branch   = 1'b0;
    rst_en   = 1'b0;
    rst_sel  = '0;
    a_sel    = '0;
    b_sel    = '0;
    c_sel    = '0;
    c_we     = 1'b0;
    alu_op   = '0;
    mem_op   = MEM_NONE;
    ir_en    = 1'b0;
    mux2_imm = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = done_q;
    err      = err_q;
    state    = state_q;
    case (state_q)
      S_FETCH, S_OPFETCH: begin mem_op = MEM_IM_RD; ir_en = 1'b1; end
      S_DECODE:           pc_inc = 1'b1;
      S_EXEC: begin
        pc_inc   = d_pc_inc;
        branch   = d_branch;
        rst_en   = d_rst_en;
        rst_sel  = d_rst_sel;
        a_sel    = d_a_sel;
        b_sel    = d_b_sel;
        c_sel    = d_c_sel;
        c_we     = d_c_we;
        alu_op   = d_alu_op;
        mem_op   = d_mem_op;
        mux2_imm = d_mux2_imm;
      end
      default: ;
    endcase
    if (rst) begin
      pc_inc = 1'b0; branch = 1'b0; rst_en = 1'b0; rst_sel = '0;
      a_sel = '0; b_sel = '0; c_sel = '0; c_we = 1'b0; alu_op = '0;
      mem_op = MEM_NONE; ir_en = 1'b0; mux2_imm = 1'b0;
      busy = 1'b0; done = 1'b0; err = 1'b0; state = '0;
    end
  end

endmodule
